// File: rtl/spi_frame_sched_if.sv
// Bus bundle between the SPI frame scheduler, its payload source, the frame requester
// and the MISO shifter. The requester/source/shifter side uses the master modport.
interface spi_frame_sched_if #(
    parameter int LEN_W = 16
);
    logic             frame_start;
    logic [LEN_W-1:0] frame_len;
    logic [7:0]       src_data;
    logic             src_valid;
    logic             src_ready;
    logic             cs_n;
    logic [2:0]       shift_bit;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             busy;
    logic             frame_done;
    logic             underrun;
    logic [LEN_W-1:0] bytes_sent;

    modport master (
        output frame_start, frame_len, src_data, src_valid, cs_n, shift_bit,
        input  src_ready, tx_data, tx_valid, busy, frame_done, underrun, bytes_sent
    );

    modport slave (
        input  frame_start, frame_len, src_data, src_valid, cs_n, shift_bit,
        output src_ready, tx_data, tx_valid, busy, frame_done, underrun, bytes_sent
    );
endinterface

// File: rtl/spi_frame_sched.sv
// Frame sequencer for the SPI MISO shifter: header, 16-bit length, payload, checksum.
// Optional macro SPI_SCHED_CSUM_EN adds the trailing checksum byte.
module spi_frame_sched #(
    parameter logic [7:0] HDR_BYTE  = 8'hA5,
    parameter logic [7:0] FILL_BYTE = 8'h00,
    parameter int         LEN_W     = 16
) (
    input logic              sck,
    input logic              sys_rst,
    spi_frame_sched_if.slave bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HDR     = 3'd1;
    localparam logic [2:0] LEN_H   = 3'd2;
    localparam logic [2:0] LEN_L   = 3'd3;
    localparam logic [2:0] PAYLOAD = 3'd4;
    localparam logic [2:0] CSUM    = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    logic [2:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] fetch_cnt;
    logic [LEN_W-1:0] bytes_sent;
    logic [7:0]       buf_q;
    logic             buf_full;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             busy;
    logic             frame_done;
    logic             underrun;
`ifdef SPI_SCHED_CSUM_EN
    logic [7:0]       csum;
`endif

    logic             byte_adv;
    logic             src_ready;
    logic             fetch;
    logic             accept;
    logic             last_payload;
    logic             load_payload;
    logic             load_fill;
    logic [7:0]       payload_byte;
    logic [15:0]      len_wire;

    assign len_wire     = 16'(len_q);
    assign byte_adv     = tx_valid & ~bus.cs_n & (bus.shift_bit == 3'd7);
    assign src_ready    = busy & (state < CSUM) & ~buf_full & (fetch_cnt < len_q);
    assign fetch        = bus.src_valid & src_ready;
    assign accept       = (state == IDLE) & bus.frame_start;
    assign last_payload = ((bytes_sent + LEN_W'(1)) == len_q);
    // A payload slot is loaded leaving LEN_L (non-empty frame) or after every non-final payload byte.
    assign load_payload = byte_adv & (((state == LEN_L) & (len_q != '0)) |
                                      ((state == PAYLOAD) & ~last_payload));
    assign load_fill    = load_payload & ~buf_full;
    assign payload_byte = buf_full ? buf_q : FILL_BYTE;

    assign bus.src_ready  = src_ready;
    assign bus.tx_data    = tx_data;
    assign bus.tx_valid   = tx_valid;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
    assign bus.underrun   = underrun;
    assign bus.bytes_sent = bytes_sent;

    // A fill consumes a source slot too, so the frame never carries more than len payload bytes.
    always_ff @(posedge sck) begin
        if (sys_rst) begin
            buf_q     <= 8'h00;
            buf_full  <= 1'b0;
            fetch_cnt <= '0;
        end else if (accept) begin
            buf_full  <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            fetch_cnt <= fetch_cnt + LEN_W'(fetch) + LEN_W'(load_fill);
            if (fetch) begin
                buf_q    <= bus.src_data;
                buf_full <= 1'b1;
            end else if (load_payload) begin
                buf_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge sck) begin
        if (sys_rst) begin
            state      <= IDLE;
            len_q      <= '0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            bytes_sent <= '0;
`ifdef SPI_SCHED_CSUM_EN
            csum       <= 8'h00;
`endif
        end else begin
            frame_done <= 1'b0;
            if (load_fill) begin
                underrun <= 1'b1;
            end
            if (load_payload) begin
                tx_data <= payload_byte;
`ifdef SPI_SCHED_CSUM_EN
                csum    <= csum + payload_byte;
`endif
            end
            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        state      <= HDR;
                        len_q      <= bus.frame_len;
                        tx_data    <= HDR_BYTE;
                        tx_valid   <= 1'b1;
                        busy       <= 1'b1;
                        bytes_sent <= '0;
                        underrun   <= 1'b0;
`ifdef SPI_SCHED_CSUM_EN
                        csum       <= 8'h00;
`endif
                    end
                end
                HDR: begin
                    if (byte_adv) begin
                        state   <= LEN_H;
                        tx_data <= len_wire[15:8];
                    end
                end
                LEN_H: begin
                    if (byte_adv) begin
                        state   <= LEN_L;
                        tx_data <= len_wire[7:0];
                    end
                end
                LEN_L: begin
                    if (byte_adv) begin
                        if (len_q != '0) begin
                            state <= PAYLOAD;
                        end else begin
`ifdef SPI_SCHED_CSUM_EN
                            state   <= CSUM;
                            tx_data <= 8'h00;
`else
                            state      <= DONE;
                            tx_data    <= 8'h00;
                            tx_valid   <= 1'b0;
                            frame_done <= 1'b1;
`endif
                        end
                    end
                end
                PAYLOAD: begin
                    if (byte_adv) begin
                        bytes_sent <= bytes_sent + LEN_W'(1);
                        if (last_payload) begin
`ifdef SPI_SCHED_CSUM_EN
                            state   <= CSUM;
                            tx_data <= csum;
`else
                            state      <= DONE;
                            tx_data    <= 8'h00;
                            tx_valid   <= 1'b0;
                            frame_done <= 1'b1;
`endif
                        end
                    end
                end
                CSUM: begin
                    if (byte_adv) begin
                        state      <= DONE;
                        tx_data    <= 8'h00;
                        tx_valid   <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_sched.sv
// Scoreboard bench for spi_frame_sched; emulates the shifter bit counter and a byte source.
// Expected frames include the checksum byte only when SPI_SCHED_CSUM_EN is defined.
module tb_spi_frame_sched;

    logic sck     = 1'b0;
    logic sys_rst = 1'b1;

    spi_frame_sched_if #(.LEN_W(16)) bus ();

    spi_frame_sched dut (
        .sck     (sck),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sck = ~sck;

    typedef struct {
        int         len;
        logic [7:0] seed;
    } vec_t;

    logic [7:0] exp_q[$];
    logic [7:0] src_q[$];
    int         pass_cnt    = 0;
    int         chk_cnt     = 0;
    int         done_pulses = 0;
    bit         src_en      = 1'b0;
    bit         src_fire    = 1'b0;
    bit         ready_seen  = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        chk_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    function automatic logic [7:0] pay_byte(input logic [7:0] seed, input int i);
        return seed + 8'(i * 17);
    endfunction

    // Shifter and source emulation; everything is settled here and held through the next posedge.
    always @(negedge sck) begin
        if (src_fire && src_q.size() > 0) src_q.delete(0);
        if (!bus.cs_n) bus.shift_bit = bus.shift_bit + 3'd1;
        bus.src_valid = src_en && (src_q.size() > 0);
        bus.src_data  = bus.src_valid ? src_q[0] : 8'h00;
        src_fire      = bus.src_valid && (bus.src_ready === 1'b1);
        if (bus.src_ready === 1'b1) ready_seen = 1'b1;
        if (bus.frame_done === 1'b1) begin
            done_pulses++;
            check_output("done_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
            check_output("done_tx_data", {24'd0, bus.tx_data}, 32'd0);
        end
        if (bus.tx_valid === 1'b1 && !bus.cs_n && bus.shift_bit == 3'd7) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("[TB] FAIL extra_byte: got %0h, expected no byte", bus.tx_data);
            end else begin
                check_output("tx_byte", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic apply_stimulus(input int len, input logic [7:0] seed, input bit late_src);
        logic [15:0] l;
        logic [7:0]  b;
        logic [7:0]  sum;
        l   = 16'(len);
        sum = 8'h00;
        done_pulses = 0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(l[15:8]);
        exp_q.push_back(l[7:0]);
        for (int i = 0; i < len; i++) begin
            b = late_src ? 8'h00 : pay_byte(seed, i);
            exp_q.push_back(b);
            if (!late_src) src_q.push_back(b);
            sum = sum + b;
        end
`ifdef SPI_SCHED_CSUM_EN
        exp_q.push_back(sum);
`endif
        src_en = !late_src;
        @(posedge sck); #1;
        bus.frame_len   = l;
        bus.frame_start = 1'b1;
        @(posedge sck); #1;
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            @(negedge sck);
            n++;
        end
        if (n >= budget) begin
            chk_cnt++;
            $display("[TB] FAIL %s_timeout: got busy after %0d cycles, expected idle", name, n);
        end
    endtask

    task automatic wait_sent(input int target, input int budget);
        int n = 0;
        while (bus.bytes_sent !== 16'(target) && n < budget) begin
            @(negedge sck);
            n++;
        end
        if (n >= budget) begin
            chk_cnt++;
            $display("[TB] FAIL wait_sent_timeout: got %0d, expected %0d", bus.bytes_sent, target);
        end
    endtask

    task automatic finish_frame(input string name, input int len, input bit exp_underrun);
        @(negedge sck);
        check_output({name, "_done_pulses"}, 32'(done_pulses), 32'd1);
        check_output({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
        check_output({name, "_bytes_sent"}, {16'd0, bus.bytes_sent}, 32'(len));
        check_output({name, "_underrun"}, {31'd0, bus.underrun}, {31'd0, exp_underrun});
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{len: 3,   seed: 8'h11};
        vecs[1] = '{len: 0,   seed: 8'h00};
        vecs[2] = '{len: 1,   seed: 8'hFF};
        vecs[3] = '{len: 5,   seed: 8'h80};
        vecs[4] = '{len: 300, seed: 8'h01};

        bus.frame_start = 1'b0;
        bus.frame_len   = 16'd0;
        bus.src_data    = 8'h00;
        bus.src_valid   = 1'b0;
        bus.cs_n        = 1'b0;
        bus.shift_bit   = 3'd0;

        repeat (3) @(posedge sck);
        @(negedge sck);
        check_output("rst_src_ready", {31'd0, bus.src_ready}, 32'd0);
        check_output("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        check_output("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check_output("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_output("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        check_output("rst_underrun", {31'd0, bus.underrun}, 32'd0);
        check_output("rst_bytes_sent", {16'd0, bus.bytes_sent}, 32'd0);
        @(posedge sck); #1;
        sys_rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            apply_stimulus(vecs[v].len, vecs[v].seed, 1'b0);
            wait_idle("vec", 4000);
            finish_frame("vec", vecs[v].len, 1'b0);
        end

        $display("[TB] late source, len=2");
        apply_stimulus(2, 8'h00, 1'b1);
        wait_sent(1, 200);
        ready_seen = 1'b0;
        src_q.push_back(8'h77);
        src_en = 1'b1;
        wait_idle("late", 200);
        check_output("late_ready_after_fetch", {31'd0, ready_seen}, 32'd0);
        finish_frame("late", 2, 1'b1);
        src_en = 1'b0;
        src_q.delete();

        $display("[TB] cs_n pause mid-payload");
        apply_stimulus(4, 8'h30, 1'b0);
        wait_sent(2, 300);
        @(posedge sck); #1;
        bus.cs_n = 1'b1;
        repeat (20) @(negedge sck);
        check_output("pause_tx_data", {24'd0, bus.tx_data}, {24'd0, pay_byte(8'h30, 2)});
        check_output("pause_bytes_sent", {16'd0, bus.bytes_sent}, 32'd2);
        check_output("pause_tx_valid", {31'd0, bus.tx_valid}, 32'd1);
        @(posedge sck); #1;
        bus.cs_n = 1'b0;
        wait_idle("pause", 300);
        finish_frame("pause", 4, 1'b0);

        $display("[TB] reset during payload");
        apply_stimulus(5, 8'h40, 1'b0);
        wait_sent(1, 300);
        @(posedge sck); #1;
        sys_rst = 1'b1;
        @(posedge sck);
        @(negedge sck);
        check_output("mrst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check_output("mrst_busy", {31'd0, bus.busy}, 32'd0);
        check_output("mrst_src_ready", {31'd0, bus.src_ready}, 32'd0);
        check_output("mrst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        @(posedge sck); #1;
        sys_rst  = 1'b0;
        exp_q.delete();
        src_q.delete();
        src_fire = 1'b0;
        repeat (10) @(negedge sck);
        check_output("mrst_no_done", 32'(done_pulses), 32'd0);
        apply_stimulus(1, 8'h5A, 1'b0);
        wait_idle("after_rst", 300);
        finish_frame("after_rst", 1, 1'b0);

        $display("[TB] frame_start while busy and in DONE");
        apply_stimulus(3, 8'h21, 1'b0);
        repeat (5) @(posedge sck);
        #1;
        bus.frame_len   = 16'd9;
        bus.frame_start = 1'b1;
        @(posedge sck); #1;
        bus.frame_start = 1'b0;
        begin
            int n = 0;
            while (bus.frame_done !== 1'b1 && n < 300) begin
                @(negedge sck);
                n++;
            end
            if (n >= 300) begin
                chk_cnt++;
                $display("[TB] FAIL busy_done_timeout: got no frame_done, expected one");
            end
        end
        bus.frame_start = 1'b1;
        @(posedge sck); #1;
        bus.frame_start = 1'b0;
        wait_idle("busy_start", 50);
        finish_frame("busy_start", 3, 1'b0);
        repeat (3) @(negedge sck);
        check_output("no_restart_busy", {31'd0, bus.busy}, 32'd0);
        check_output("no_restart_tx_valid", {31'd0, bus.tx_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
